// File: rtl/logic_gate_pkg.sv
// logic_gate_pkg: shared opcodes, state encoding and constants for the logic_gate family
package logic_gate_pkg;
  localparam logic [2:0] OP_NOT_A = 3'd0;
  localparam logic [2:0] OP_AND   = 3'd1;
  localparam logic [2:0] OP_OR    = 3'd2;
  localparam logic [2:0] OP_XOR   = 3'd3;
  localparam logic [2:0] OP_NAND  = 3'd4;
  localparam logic [2:0] OP_NOR   = 3'd5;
  localparam logic [2:0] OP_XNOR  = 3'd6;
  localparam logic [2:0] OP_NOT_B = 3'd7;
  localparam logic [63:0] ZERO_DATA    = 64'd0;
  localparam logic [63:0] ZERO_CONTROL = 64'd0;
  localparam logic [63:0] ONE_CONTROL  = 64'd1;
  typedef enum logic {STATE_IDLE, STATE_INPUT} state_t;
endpackage

// File: rtl/logic_gate_alu.sv
// logic_gate_alu: combinational bitwise operation selected by opcode
module logic_gate_alu
  import logic_gate_pkg::*;
#(
  parameter int DATA_SIZE = 64
) (
  input  logic [2:0]           OPCODE,
  input  logic [DATA_SIZE-1:0] DATA_A,
  input  logic [DATA_SIZE-1:0] DATA_B,
  output logic [DATA_SIZE-1:0] DATA_OUT
);
  // full-width bitwise result for the selected opcode
  always_comb
    DATA_OUT = OPCODE == OP_NOT_A ? ~DATA_A :
               OPCODE == OP_AND   ? DATA_A & DATA_B :
               OPCODE == OP_OR    ? DATA_A | DATA_B :
               OPCODE == OP_XOR   ? DATA_A ^ DATA_B :
               OPCODE == OP_NAND  ? ~(DATA_A & DATA_B) :
               OPCODE == OP_NOR   ? ~(DATA_A | DATA_B) :
               OPCODE == OP_XNOR  ? ~(DATA_A ^ DATA_B) :
                                    ~DATA_B;
endmodule

// File: rtl/vector_logic_gate.sv
// vector_logic_gate: requests operand elements, applies a bitwise op and streams results
module vector_logic_gate
  import logic_gate_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic [2:0]              OPCODE,
  input  logic [CONTROL_SIZE-1:0] SIZE_IN,
  output logic                    DATA_ENABLE,
  input  logic                    DATA_A_IN_ENABLE,
  input  logic                    DATA_B_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    DATA_A_IN,
  input  logic [DATA_SIZE-1:0]    DATA_B_IN,
  output logic                    DATA_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]    DATA_OUT
);
  localparam logic [CONTROL_SIZE-1:0] C_ZERO = CONTROL_SIZE'(ZERO_CONTROL);
  localparam logic [CONTROL_SIZE-1:0] C_ONE  = CONTROL_SIZE'(ONE_CONTROL);
  localparam logic [DATA_SIZE-1:0]    D_ZERO = DATA_SIZE'(ZERO_DATA);
  state_t                  state, state_d;
  logic [2:0]              opcode_r;
  logic [CONTROL_SIZE-1:0] size_r, index;
  logic [DATA_SIZE-1:0]    a_r, b_r, a_sel, b_sel, alu_out;
  logic                    a_cap, b_cap, need_a, need_b, a_in, b_in, done, last, start_ok;
  logic_gate_alu #(.DATA_SIZE(DATA_SIZE)) u_alu (
    .OPCODE   (opcode_r),
    .DATA_A   (a_sel),
    .DATA_B   (b_sel),
    .DATA_OUT (alu_out)
  );
  // operand arrival, element completion and next state; unary ops ignore the unused operand
  always_comb begin
    need_a   = opcode_r != OP_NOT_B;
    need_b   = opcode_r != OP_NOT_A;
    a_in     = state == STATE_INPUT && need_a && DATA_A_IN_ENABLE;
    b_in     = state == STATE_INPUT && need_b && DATA_B_IN_ENABLE;
    a_sel    = a_in ? DATA_A_IN : a_r;
    b_sel    = b_in ? DATA_B_IN : b_r;
    done     = state == STATE_INPUT && (!need_a || a_cap || a_in) && (!need_b || b_cap || b_in);
    last     = index == size_r - C_ONE;
    start_ok = state == STATE_IDLE && START;
    state_d  = state == STATE_IDLE ? (START && SIZE_IN != C_ZERO ? STATE_INPUT : STATE_IDLE) :
               (done && last ? STATE_IDLE : STATE_INPUT);
  end
  // state register
  always_ff @(posedge CLK)
    state <= RST ? STATE_IDLE : state_d;
  // datapath registers and single-cycle strobes
  always_ff @(posedge CLK) begin
    if (RST) begin
      opcode_r        <= OP_NOT_A;
      size_r          <= C_ZERO;
      index           <= C_ZERO;
      a_r             <= D_ZERO;
      b_r             <= D_ZERO;
      a_cap           <= 1'b0;
      b_cap           <= 1'b0;
      READY           <= 1'b0;
      DATA_ENABLE     <= 1'b0;
      DATA_OUT_ENABLE <= 1'b0;
      DATA_OUT        <= D_ZERO;
    end else begin
      READY           <= 1'b0;
      DATA_ENABLE     <= 1'b0;
      DATA_OUT_ENABLE <= 1'b0;
      if (start_ok) begin
        opcode_r    <= OPCODE;
        size_r      <= SIZE_IN;
        index       <= C_ZERO;
        READY       <= SIZE_IN == C_ZERO;
        DATA_ENABLE <= SIZE_IN != C_ZERO;
      end
      if (a_in) a_r <= DATA_A_IN;
      if (b_in) b_r <= DATA_B_IN;
      if (done) begin
        a_cap           <= 1'b0;
        b_cap           <= 1'b0;
        DATA_OUT        <= alu_out;
        DATA_OUT_ENABLE <= 1'b1;
        READY           <= last;
        DATA_ENABLE     <= !last;
        index           <= last ? index : index + C_ONE;
      end else begin
        a_cap <= a_cap | a_in;
        b_cap <= b_cap | b_in;
      end
    end
  end
endmodule

// File: tb/tb_vector_logic_gate.sv
// tb_vector_logic_gate: directed and randomized checks against a behavioural model
module tb_vector_logic_gate;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        READY;
  logic [2:0]  OPCODE = 3'd0;
  logic [63:0] SIZE_IN = 64'd0;
  logic        DATA_ENABLE;
  logic        DATA_A_IN_ENABLE = 1'b0;
  logic        DATA_B_IN_ENABLE = 1'b0;
  logic [63:0] DATA_A_IN = 64'd0;
  logic [63:0] DATA_B_IN = 64'd0;
  logic        DATA_OUT_ENABLE;
  logic [63:0] DATA_OUT;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] last_out = 64'd0;

  vector_logic_gate #(.DATA_SIZE(64), .CONTROL_SIZE(64)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .START            (START),
    .READY            (READY),
    .OPCODE           (OPCODE),
    .SIZE_IN          (SIZE_IN),
    .DATA_ENABLE      (DATA_ENABLE),
    .DATA_A_IN_ENABLE (DATA_A_IN_ENABLE),
    .DATA_B_IN_ENABLE (DATA_B_IN_ENABLE),
    .DATA_A_IN        (DATA_A_IN),
    .DATA_B_IN        (DATA_B_IN),
    .DATA_OUT_ENABLE  (DATA_OUT_ENABLE),
    .DATA_OUT         (DATA_OUT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      3'd0: return ~a;
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return a ^ b;
      3'd4: return ~(a & b);
      3'd5: return ~(a | b);
      3'd6: return ~(a ^ b);
      default: return ~b;
    endcase
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ready"}, READY, 0);
    chk({tag, "_den"}, DATA_ENABLE, 0);
    chk({tag, "_oen"}, DATA_OUT_ENABLE, 0);
  endtask

  task automatic start_vec(input logic [2:0] op, input logic [63:0] n);
    START = 1'b1;
    OPCODE = op;
    SIZE_IN = n;
    step();
    START = 1'b0;
    OPCODE = $urandom_range(0, 7);
    SIZE_IN = rand64();
    chk("start_den", DATA_ENABLE, n != 0);
    chk("start_ready", READY, n == 0);
    chk("start_oen", DATA_OUT_ENABLE, 0);
  endtask

  // feed one element: A arrives da cycles and B db cycles after the request;
  // an operand the opcode does not use gets random enables and data instead
  task automatic elem(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                      input int da, input int db, input bit is_last);
    bit na = op != 3'd7;
    bit nb = op != 3'd0;
    int maxd = (na && nb) ? (da > db ? da : db) : (na ? da : db);
    logic [63:0] exp = ref_op(op, a, b);
    for (int t = 0; t <= maxd; t++) begin
      DATA_A_IN_ENABLE = na ? (t == da) : 1'($urandom);
      DATA_A_IN = (na && t == da) ? a : rand64();
      DATA_B_IN_ENABLE = nb ? (t == db) : 1'($urandom);
      DATA_B_IN = (nb && t == db) ? b : rand64();
      step();
      if (t < maxd) begin
        chk_quiet("wait");
        chk("hold_data", DATA_OUT, last_out);
      end
    end
    DATA_A_IN_ENABLE = 1'b0;
    DATA_B_IN_ENABLE = 1'b0;
    chk("out_en", DATA_OUT_ENABLE, 1);
    chk("out_data", DATA_OUT, exp);
    chk("out_ready", READY, is_last);
    chk("out_den", DATA_ENABLE, !is_last);
    last_out = exp;
  endtask

  initial begin
    logic [2:0]  op;
    logic [63:0] a, b;
    int          n;
    // reset held with START high
    START = 1'b1;
    step();
    step();
    chk_quiet("reset");
    chk("reset_data", DATA_OUT, 0);
    RST = 1'b0;
    START = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_quiet("idle");
    end
    // NOT A with random B noise
    start_vec(3'd0, 64'd2);
    elem(3'd0, 64'h0, rand64(), 1, 0, 1'b0);
    elem(3'd0, 64'hFFFF_0000_FFFF_0000, rand64(), 2, 0, 1'b1);
    chk("nota_2nd", last_out, 64'h0000_FFFF_0000_FFFF);
    step();
    chk_quiet("after_ready");
    // XOR with A first, B first, and both together
    start_vec(3'd3, 64'd1);
    elem(3'd3, 64'hF0, 64'hFF, 0, 3, 1'b1);
    chk("xor_ab", DATA_OUT, 64'h0F);
    start_vec(3'd3, 64'd1);
    elem(3'd3, 64'hF0, 64'hFF, 3, 0, 1'b1);
    start_vec(3'd3, 64'd1);
    elem(3'd3, 64'hF0, 64'hFF, 0, 0, 1'b1);
    // every opcode on A=0xC, B=0xA
    for (int o = 0; o < 8; o++) begin
      start_vec(3'(o), 64'd1);
      elem(3'(o), 64'hC, 64'hA, $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
    end
    chk("nor_ca", ref_op(3'd5, 64'hC, 64'hA), 64'hFFFF_FFFF_FFFF_FFF1);
    // zero-length vector
    start_vec(3'd2, 64'd0);
    step();
    chk_quiet("size0_after");
    // START during INPUT is ignored
    start_vec(3'd1, 64'd2);
    START = 1'b1;
    OPCODE = 3'd0;
    SIZE_IN = 64'd0;
    step();
    START = 1'b0;
    chk_quiet("start_in_input");
    elem(3'd1, rand64(), rand64(), 1, 2, 1'b0);
    elem(3'd1, rand64(), rand64(), 0, 1, 1'b1);
    // back-to-back START on the READY cycle
    start_vec(3'd2, 64'd1);
    elem(3'd2, rand64(), rand64(), 1, 1, 1'b1);
    start_vec(3'd5, 64'd1);
    elem(3'd5, rand64(), rand64(), 2, 0, 1'b1);
    // randomized vectors
    for (int v = 0; v < 8; v++) begin
      op = 3'($urandom_range(0, 7));
      n = $urandom_range(1, 4);
      start_vec(op, 64'(n));
      for (int i = 0; i < n; i++) begin
        a = rand64();
        b = rand64();
        elem(op, a, b, $urandom_range(0, 3), $urandom_range(0, 3), i == n - 1);
      end
    end
    // all-ones length does not finish early
    start_vec(3'd6, {64{1'b1}});
    for (int i = 0; i < 3; i++) elem(3'd6, rand64(), rand64(), $urandom_range(0, 1), $urandom_range(0, 1), 1'b0);
    RST = 1'b1;
    step();
    RST = 1'b0;
    last_out = 64'd0;
    // reset mid-vector aborts without READY
    start_vec(3'd1, 64'd4);
    elem(3'd1, rand64(), rand64(), 0, 1, 1'b0);
    elem(3'd1, rand64(), rand64(), 2, 0, 1'b0);
    RST = 1'b1;
    step();
    chk_quiet("midreset");
    chk("midreset_data", DATA_OUT, 0);
    RST = 1'b0;
    last_out = 64'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_quiet("post_reset");
    end
    start_vec(3'd1, 64'd1);
    elem(3'd1, 64'h0123_4567_89AB_CDEF, 64'hFF00_FF00_FF00_FF00, 1, 0, 1'b1);
    chk("post_reset_and", DATA_OUT, 64'h0100_4500_8900_CD00);
    step();
    chk_quiet("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vector_logic_gate.md
Name: vector_logic_gate

Overview:
- Vector-level sequencer for the logic_gate family.
- Requests operand elements from an upstream producer and applies a selected bitwise operation (NOT/AND/OR/XOR and complements) to each element.
- Streams results downstream with per-element valid strobes.
- Sits between the NTM memory/controller datapath and the element-level logic gates. It is the producer/consumer end of the element handshake the scalar gates expose.

Parameters:
- DATA_SIZE, 64, width of one vector element.
- CONTROL_SIZE, 64, width of the length and index counters.

Ports:
- CLK  input  1  clock
- RST  input  1  synchronous, active-high reset
- START  input  1  one-cycle pulse; starts a vector operation
- READY  output  1  one-cycle pulse when the vector is complete
- OPCODE  input  3  operation, sampled with START
- SIZE_IN  input  CONTROL_SIZE  number of elements, sampled with START
- DATA_ENABLE  output  1  one-cycle request for the next element
- DATA_A_IN_ENABLE  input  1  DATA_A_IN valid this cycle
- DATA_B_IN_ENABLE  input  1  DATA_B_IN valid this cycle
- DATA_A_IN  input  DATA_SIZE  operand A element
- DATA_B_IN  input  DATA_SIZE  operand B element
- DATA_OUT_ENABLE  output  1  DATA_OUT valid this cycle
- DATA_OUT  output  DATA_SIZE  result element

Behaviour:
- Reset: on a clock edge with RST=1, all outputs go to 0 and state goes to IDLE. Index, latched size/opcode, operand registers and captured flags are cleared. Reset mid-vector aborts with no READY.
- Opcodes:
  - 0 = NOT A
  - 1 = A AND B
  - 2 = A OR B
  - 3 = A XOR B
  - 4 = NAND
  - 5 = NOR
  - 6 = XNOR
  - 7 = NOT B
- Opcodes 0 and 7 are unary. For op 0 only A is needed and B enables are ignored; for op 7 only B is needed and A enables are ignored.
- State machine: IDLE, INPUT.
- IDLE:
  - On START, latch OPCODE and SIZE_IN and clear the index.
  - If SIZE_IN=0: READY=1 next cycle, stay in IDLE, no DATA_ENABLE.
  - Else: DATA_ENABLE=1 next cycle, go to INPUT.
  - START in INPUT is ignored.
- INPUT:
  - Each required operand is captured on the first edge its enable is high. A and B may arrive in the same cycle or in different cycles, in any order.
  - A repeated enable for an already-captured operand overwrites it.
  - Enables in IDLE are ignored.
- Result timing:
  - On the edge where the last required operand is sampled, DATA_OUT is registered as the result. The captured flags clear on that same edge.
  - DATA_OUT_ENABLE=1 in the following cycle, for exactly one cycle.
  - The data path is combinational from the raw inputs when an operand arrives that cycle, otherwise from its captured register, so the latency is exactly 1 cycle after the last operand.
- End of element:
  - If index = latched size - 1: READY=1 in the same cycle as the last DATA_OUT_ENABLE, then go to IDLE.
  - Else: index increments, DATA_ENABLE=1 in the same cycle as DATA_OUT_ENABLE, stay in INPUT.
- Pulse rules:
  - DATA_ENABLE, DATA_OUT_ENABLE and READY are single-cycle pulses, 0 otherwise.
  - DATA_OUT holds its last value between strobes.
- Width rules: all operations are full-width bitwise, with no truncation. The index counter is CONTROL_SIZE wide; SIZE_IN = all-ones is legal and does not wrap before completion.
- A new START is accepted on the cycle READY is high, because state is already IDLE.

Decomposition:
- Shared package (logic_gate_pkg): opcode localparams (OP_NOT_A … OP_NOT_B), the state enum, and ZERO_DATA/ZERO_CONTROL/ONE_CONTROL constants.
- One natural sub-module: logic_gate_alu. It is purely combinational (OPCODE, A, B → result) and reusable by the scalar and matrix variants.

Test Plan:
- Reset/idle: RST=1 for 2 cycles with START=1 → all outputs 0; after release no DATA_ENABLE until a fresh START.
- NOT A: OPCODE=0, SIZE_IN=2, DATA_SIZE=64, A = 0x0, then 0xFFFF_0000_FFFF_0000.
  - Expected DATA_OUT: 0xFFFF_FFFF_FFFF_FFFF, then 0x0000_FFFF_0000_FFFF.
  - READY coincides with the 2nd DATA_OUT_ENABLE.
  - B enables are pulsed randomly and have no effect.
- Split arrival XOR: OPCODE=3, SIZE_IN=1, A=0xF0 at cycle t, B=0xFF at t+3 → DATA_OUT=0x0F with DATA_OUT_ENABLE at t+4. Repeat with B first and with both in the same cycle: same result and same 1-cycle latency.
- All opcodes: A=0xC, B=0xA on 8 single-element runs → results 0x…F3, 0x8, 0xE, 0x6, 0x…F7, 0x…F1, 0x…F9, 0x…F5.
- Boundaries: SIZE_IN=0 → READY 1 cycle after START with no DATA_ENABLE or DATA_OUT_ENABLE. START during INPUT ignored. Back-to-back START on the READY cycle is accepted.
- Reset mid-vector: SIZE_IN=4, assert RST after the 2nd result → outputs 0, no READY. A subsequent SIZE_IN=1 run completes correctly.
